mil_sram_ctrl: RTL and testbench

//  Memory-side stage downstream of the dual MIL/SPI bridge: consumes its single-word memory

---
 rtl/mil_mem_pkg.sv | 29 ++
 rtl/mil_sram_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mil_sram_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mil_mem_pkg.sv
// mil_mem_pkg: shared types and constants for the MIL memory-side SRAM controller.
// Optional feature macro: MEM_PARITY_EN (adds one even-parity bit per stored word).
package mil_mem_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    LATCH   = 3'd2,
    TURN    = 3'd3,
    WR_ACC  = 3'd4,
    WR_HOLD = 3'd5
  } mem_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

`ifdef MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Even parity: XOR of all data bits (caller zero-extends narrower words)
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mil_sram_ctrl.sv
// mil_sram_ctrl: executes single-word read/write requests from the bridge arbiter as
// asynchronous-SRAM cycles with programmable wait states and read->next turnaround.
// Optional feature macro: MEM_PARITY_EN (stores parity in the SRAM MSB, checks it on reads
// and exposes parity_err).
module mil_sram_ctrl
  import mil_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_rd_req,
  input  logic                    mem_wr_req,
  output logic                    mem_busy,
  output logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_rd_done,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W+PAR_W-1:0] sram_dq_o,
  output logic                    sram_dq_oe,
  input  logic [DATA_W+PAR_W-1:0] sram_dq_i,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n
`ifdef MEM_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int SW      = DATA_W + PAR_W;
  localparam int CNT_MAX = (WAIT_STATES > TURNAROUND) ? WAIT_STATES : TURNAROUND;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] TURN_LAST = (TURNAROUND > 0) ? CNT_W'(TURNAROUND - 1) : '0;

  mem_state_t        r_state;
  mem_state_t        w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_ce_n;
  logic              w_oe_n;
  logic              w_we_n;
  logic              w_dq_oe;
  logic              w_rd_sample;

  logic              r_busy;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_done;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [SW-1:0]     r_dq_o;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;

  // Data is captured on the edge that ends the last read strobe cycle
  assign w_rd_sample = (r_state == RD_ACC) && (r_cnt == ACC_LAST);

  // Next-state / wait counter, and the strobe levels belonging to the next state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ce_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;
    w_dq_oe      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (mem_wr_req) begin
          w_state_next = WR_ACC;   // write wins; a simultaneous read is dropped
        end else if (mem_rd_req) begin
          w_state_next = RD_ACC;
        end
      end
      RD_ACC: begin
        if (r_cnt == ACC_LAST) begin
          w_state_next = LATCH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      LATCH: begin
        w_cnt_next   = '0;
        w_state_next = (TURNAROUND == 0) ? IDLE : TURN;
      end
      TURN: begin
        if (r_cnt == TURN_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WR_ACC: begin
        if (r_cnt == ACC_LAST) begin
          w_state_next = WR_HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      WR_HOLD: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    // Read states never drive the bus, so dq_oe and oe_n=0 cannot coincide
    case (w_state_next)
      RD_ACC: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
      end
      WR_ACC: begin
        w_ce_n  = 1'b0;
        w_we_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      WR_HOLD: begin
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // State, registered SRAM pins, request capture and read-data latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_rdata     <= '0;
      r_rd_done   <= 1'b0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= (w_state_next != IDLE);
      r_rd_done <= (w_state_next == LATCH);
      r_dq_oe   <= w_dq_oe;
      r_ce_n    <= w_ce_n;
      r_oe_n    <= w_oe_n;
      r_we_n    <= w_we_n;
      if (r_state == IDLE && (mem_wr_req || mem_rd_req)) begin
        r_sram_addr <= mem_addr;
      end
      if (r_state == IDLE && mem_wr_req) begin
`ifdef MEM_PARITY_EN
        r_dq_o <= {even_parity(64'(mem_wdata)), mem_wdata};
`else
        r_dq_o <= mem_wdata;
`endif
      end
      if (w_rd_sample) begin
        r_rdata <= sram_dq_i[DATA_W-1:0];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic r_parity_err;

  // Parity flag is produced on the same edge as rd_done so both pulse together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_rd_sample &&
                      (sram_dq_i[SW-1] != even_parity(64'(sram_dq_i[DATA_W-1:0])));
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign mem_busy    = r_busy;
  assign mem_rdata   = r_rdata;
  assign mem_rd_done = r_rd_done;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_o   = r_dq_o;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_mil_sram_ctrl.sv
// tb_mil_sram_ctrl: self-checking bench for mil_sram_ctrl (WAIT_STATES=2, TURNAROUND=1).
// Build with MEM_PARITY_EN defined to also exercise the parity path.
module tb_mil_sram_ctrl;
  import mil_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WS = 2;
  localparam int TA = 1;
  localparam int SW = DW + PAR_W;

  // Expected cycle counts, counted in cycles after the accept edge
  localparam int WR_BUSY    = WS + 2;
  localparam int WR_WE      = WS + 1;
  localparam int WR_DQOE    = WS + 2;
  localparam int RD_OE      = WS + 1;
  localparam int RD_BUSY    = WS + 2 + TA;
  localparam int RD_DONE_AT = WS + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic          mem_busy;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd_done;
  logic [AW-1:0] sram_addr;
  logic [SW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic [SW-1:0] sram_dq_i;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
`ifdef MEM_PARITY_EN
  logic          parity_err;
`endif

  mil_sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .TURNAROUND(TA)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rd_done(mem_rd_done),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
`ifdef MEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: array written only from the main initial block
  logic [SW-1:0] sram [0:65535];
  logic          prev_we = 1'b1;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : '0;

  // Reference model: data last written per address, else the power-up pattern
  logic [15:0] ref_mem [logic [15:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          busy;
    int          we;
    int          dqoe;
    int          oe;
    int          done_n;
    int          done_at;
    int          turn;
    int          conflict;
    int          bad_addr;
    int          bad_dq;
    int          perr_n;
    int          perr_off;
    logic [15:0] rdata;
    bit          timeout;
  } meas_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_busy;
    int          exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [SW-1:0] mk_word(input logic [15:0] v);
`ifdef MEM_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // SRAM write happens on the rising edge of we_n while the chip stays selected
  task automatic sram_tick();
    if (prev_we === 1'b0 && sram_we_n === 1'b1 && sram_ce_n === 1'b0)
      sram[sram_addr] = sram_dq_o;
    prev_we = sram_we_n;
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 20 && mem_busy; g++) begin
      @(negedge clk);
      sram_tick();
    end
    check("wait_idle", {31'd0, mem_busy}, 32'd0);
  endtask

  // Issue one request at an idle cycle and measure the resulting SRAM cycle
  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, output meas_t m);
    m = '{default: 0};
    wait_idle();
    mem_rd_req = rd;
    mem_wr_req = wr;
    mem_addr   = a;
    mem_wdata  = d;
    @(posedge clk);
    #1;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sram_tick();
      if (!mem_busy) break;
      m.busy++;
      if (!sram_we_n) m.we++;
      if (sram_dq_oe) m.dqoe++;
      if (!sram_oe_n) m.oe++;
      if (sram_dq_oe && !sram_oe_n) m.conflict++;
      if (sram_ce_n && sram_oe_n && sram_we_n && !sram_dq_oe) m.turn++;
      if (!sram_ce_n && sram_addr !== a) m.bad_addr++;
      if (sram_dq_oe && sram_dq_o !== mk_word(d)) m.bad_dq++;
      if (mem_rd_done) begin
        m.done_n++;
        m.done_at = k;
        m.rdata   = mem_rdata;
      end
`ifdef MEM_PARITY_EN
      if (parity_err) m.perr_n++;
      if (parity_err && !mem_rd_done) m.perr_off++;
`endif
    end
    m.timeout = mem_busy;
  endtask

  // Compare a measured transaction against the specification-level model
  task automatic check_txn(input string tag, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] d, input meas_t m);
    bit is_rd;
    is_rd = rd && !wr;
    $display("txn %s rd=%0b wr=%0b addr=0x%04h wdata=0x%04h busy=%0d we=%0d dqoe=%0d done_at=%0d rdata=0x%04h",
             tag, rd, wr, a, d, m.busy, m.we, m.dqoe, m.done_at, m.rdata);
    check({tag, ".timeout"}, {31'd0, m.timeout}, 32'd0);
    check({tag, ".busy"}, m.busy, wr ? WR_BUSY : RD_BUSY);
    check({tag, ".we_low"}, m.we, wr ? WR_WE : 0);
    check({tag, ".dq_oe"}, m.dqoe, wr ? WR_DQOE : 0);
    check({tag, ".oe_low"}, m.oe, is_rd ? RD_OE : 0);
    check({tag, ".rd_done_n"}, m.done_n, is_rd ? 1 : 0);
    check({tag, ".conflict"}, m.conflict, 0);
    check({tag, ".addr"}, m.bad_addr, 0);
    check({tag, ".dq_o"}, m.bad_dq, 0);
    if (is_rd) begin
      check({tag, ".rd_done_at"}, m.done_at, RD_DONE_AT);
      check({tag, ".rdata"}, m.rdata, ref_read(a));
      check({tag, ".turn_ge"}, (m.turn >= TA) ? 1 : 0, 1);
    end
`ifdef MEM_PARITY_EN
    check({tag, ".perr_n"}, m.perr_n, 0);
`endif
    if (wr) ref_mem[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [9];
    meas_t m;
    int    last_oe, first_we, gap, done_n;
    bit    wr_acc;
    logic [15:0] rd_val;

    for (int i = 0; i < 65536; i++) sram[i] = mk_word(16'(i) ^ 16'h5A5A);

    // inputs, expected busy cycles, expected rd_done count, expected read data
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hA5A5, WR_BUSY, 0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, RD_BUSY, 1, 16'hA5A5};
    vecs[2] = '{1'b1, 1'b1, 16'h0020, 16'h1234, WR_BUSY, 0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 16'h0000, RD_BUSY, 1, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, RD_BUSY, 1, 16'h5A6A};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hC3C3, WR_BUSY, 0, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, RD_BUSY, 1, 16'hC3C3};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0001, WR_BUSY, 0, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, RD_BUSY, 1, 16'h0001};

    rst = 1'b1;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", {31'd0, mem_busy}, 0);
    check("rst.rd_done", {31'd0, mem_rd_done}, 0);
    check("rst.rdata", mem_rdata, 0);
    check("rst.strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    check("rst.dq_oe", {31'd0, sram_dq_oe}, 0);
    check("rst.addr", sram_addr, 0);
    check("rst.dq_o", 32'(sram_dq_o), 0);
`ifdef MEM_PARITY_EN
    check("rst.parity_err", {31'd0, parity_err}, 0);
`endif
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, m);
      check($sformatf("vec%0d.busy", i), m.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d.done", i), m.done_n, vecs[i].exp_done);
      if (vecs[i].exp_done != 0)
        check($sformatf("vec%0d.rdata", i), m.rdata, vecs[i].exp_rdata);
      check_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, m);
    end

    // Read followed by a write request held high throughout the read
    wait_idle();
    mem_rd_req = 1'b1;
    mem_addr   = 16'h0010;
    @(posedge clk);
    #1;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b1;
    mem_addr   = 16'h0040;
    mem_wdata  = 16'h0BEE;
    last_oe = 0; first_we = 0; gap = 0; done_n = 0; wr_acc = 1'b0; rd_val = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sram_tick();
      if (!sram_oe_n) last_oe = k;
      if (!sram_we_n && first_we == 0) first_we = k;
      if (last_oe != 0 && first_we == 0 && sram_ce_n && sram_oe_n && sram_we_n && !sram_dq_oe)
        gap++;
      if (mem_rd_done) begin
        done_n++;
        rd_val = mem_rdata;
      end
      if (wr_acc && !mem_busy) break;
      if (!mem_busy && mem_wr_req) begin
        @(posedge clk);
        #1;
        mem_wr_req = 1'b0;
        wr_acc = 1'b1;
      end
    end
    $display("txn b2b read@0x0010 then write@0x0040 last_oe=%0d first_we=%0d gap=%0d rdata=0x%04h",
             last_oe, first_we, gap, rd_val);
    check("b2b.write_accepted", {31'd0, wr_acc}, 1);
    check("b2b.idle_at_end", {31'd0, mem_busy}, 0);
    check("b2b.gap_ge1", (gap >= 1) ? 1 : 0, 1);
    check("b2b.no_early_write", (first_we > last_oe) ? 1 : 0, 1);
    check("b2b.rd_done_n", done_n, 1);
    check("b2b.rdata", rd_val, ref_read(16'h0010));
    ref_mem[16'h0040] = 16'h0BEE;
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, m);
    check_txn("b2b_readback", 1'b1, 1'b0, 16'h0040, 16'h0000, m);

    // Reset asserted in the middle of a write strobe
    wait_idle();
    mem_wr_req = 1'b1;
    mem_addr   = 16'h0060;
    mem_wdata  = 16'h7777;
    @(posedge clk);
    #1;
    mem_wr_req = 1'b0;
    @(negedge clk);
    sram_tick();
    check("rstw.in_wr_acc", {31'd0, sram_we_n}, 0);
    @(negedge clk);
    sram_tick();
    rst = 1'b1;
    @(negedge clk);
    sram_tick();
    $display("txn rst_mid_write addr=0x0060 we_n=%0b ce_n=%0b dq_oe=%0b busy=%0b",
             sram_we_n, sram_ce_n, sram_dq_oe, mem_busy);
    check("rstw.we_n", {31'd0, sram_we_n}, 1);
    check("rstw.ce_n", {31'd0, sram_ce_n}, 1);
    check("rstw.dq_oe", {31'd0, sram_dq_oe}, 0);
    check("rstw.busy", {31'd0, mem_busy}, 0);
    check("rstw.rdata", mem_rdata, 0);
    rst = 1'b0;

`ifdef MEM_PARITY_EN
    // Corrupted stored word must raise parity_err together with rd_done
    run_txn(1'b0, 1'b1, 16'h0050, 16'h0001, m);
    check_txn("par_wr", 1'b0, 1'b1, 16'h0050, 16'h0001, m);
    check("par.stored_msb", {31'd0, sram[16'h0050][16]}, 1);
    sram[16'h0050][3] = ~sram[16'h0050][3];
    run_txn(1'b1, 1'b0, 16'h0050, 16'h0000, m);
    $display("txn par_rd addr=0x0050 rdata=0x%04h perr_n=%0d done_at=%0d", m.rdata, m.perr_n, m.done_at);
    check("par.perr_n", m.perr_n, 1);
    check("par.perr_with_done", m.perr_off, 0);
    check("par.rdata", m.rdata, 16'h0009);
    check("par.done_at", m.done_at, RD_DONE_AT);
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [15:0] a;
      logic [15:0] d;
      op = $urandom_range(0, 2);
      a  = 16'h0100 + 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      run_txn(op != 1, op != 0, a, d, m);
      check_txn($sformatf("rnd%0d", i), op != 1, op != 0, a, d, m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
